// File: rtl/apu_envelope_length.sv
// Per-channel envelope decay and length counter, clocked by the frame sequencer's
// quarter-frame (envelope) and half-frame (length) toggle clocks.
module apu_envelope_length #(
   parameter int LEN_W = 8,
   parameter int ENV_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fc_qfr_clk,
   input  logic             fc_hfr_clk,
   input  logic             enable,
   input  logic             wr_ctrl,
   input  logic [ENV_W+1:0] ctrl_data,
   input  logic             wr_len,
   input  logic [4:0]       len_index,
   output logic [ENV_W-1:0] volume,
   output logic             len_active
);

   // wr_ctrl and wr_len are single-cycle strobes with no back-pressure: the
   // block always accepts them on the clk edge that ends the strobe cycle.

   logic             halt_loop;
   logic             const_vol;
   logic [ENV_W-1:0] vol_period;
   logic             start;
   logic [ENV_W-1:0] divider;
   logic [ENV_W-1:0] decay;
   logic [LEN_W-1:0] len;
   logic             qfr_d;
   logic             hfr_d;
   logic             armed;
   logic             qfr_evt;
   logic             hfr_evt;
   logic [ENV_W-1:0] env_out;

   function automatic logic [LEN_W-1:0] len_table(input logic [4:0] idx);
      logic [LEN_W-1:0] v;
      case (idx)
         5'd0:  v = LEN_W'(10);
         5'd1:  v = LEN_W'(254);
         5'd2:  v = LEN_W'(20);
         5'd3:  v = LEN_W'(2);
         5'd4:  v = LEN_W'(40);
         5'd5:  v = LEN_W'(4);
         5'd6:  v = LEN_W'(80);
         5'd7:  v = LEN_W'(6);
         5'd8:  v = LEN_W'(160);
         5'd9:  v = LEN_W'(8);
         5'd10: v = LEN_W'(60);
         5'd11: v = LEN_W'(10);
         5'd12: v = LEN_W'(14);
         5'd13: v = LEN_W'(12);
         5'd14: v = LEN_W'(26);
         5'd15: v = LEN_W'(14);
         5'd16: v = LEN_W'(12);
         5'd17: v = LEN_W'(16);
         5'd18: v = LEN_W'(24);
         5'd19: v = LEN_W'(18);
         5'd20: v = LEN_W'(48);
         5'd21: v = LEN_W'(20);
         5'd22: v = LEN_W'(96);
         5'd23: v = LEN_W'(22);
         5'd24: v = LEN_W'(192);
         5'd25: v = LEN_W'(24);
         5'd26: v = LEN_W'(72);
         5'd27: v = LEN_W'(26);
         5'd28: v = LEN_W'(16);
         5'd29: v = LEN_W'(28);
         5'd30: v = LEN_W'(32);
         default: v = LEN_W'(30);
      endcase
      return v;
   endfunction

   // armed masks the cycle right after reset so a toggle clock already high
   // at release is not mistaken for a rising edge.
   assign qfr_evt = armed & fc_qfr_clk & ~qfr_d;
   assign hfr_evt = armed & fc_hfr_clk & ~hfr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halt_loop  <= 1'b0;
         const_vol  <= 1'b0;
         vol_period <= '0;
         start      <= 1'b0;
         divider    <= '0;
         decay      <= '0;
         len        <= '0;
         qfr_d      <= 1'b0;
         hfr_d      <= 1'b0;
         armed      <= 1'b0;
      end else begin
         armed <= 1'b1;
         qfr_d <= fc_qfr_clk;
         hfr_d <= fc_hfr_clk;

         if (wr_ctrl) begin
            halt_loop  <= ctrl_data[ENV_W+1];
            const_vol  <= ctrl_data[ENV_W];
            vol_period <= ctrl_data[ENV_W-1:0];
         end

         if (!enable)
            len <= '0;
         else if (wr_len)
            len <= len_table(len_index);
         else if (hfr_evt && (len != '0) && !halt_loop)
            len <= len - 1'b1;

         if (qfr_evt) begin
            if (start) begin
               start   <= 1'b0;
               decay   <= '1;
               divider <= vol_period;
            end else if (divider == '0) begin
               divider <= vol_period;
               if (decay != '0)
                  decay <= decay - 1'b1;
               else if (halt_loop)
                  decay <= '1;
            end else begin
               divider <= divider - 1'b1;
            end
         end

         // A length write restarts the envelope even when it lands on a quarter frame.
         if (wr_len)
            start <= 1'b1;
      end
   end

   assign env_out    = const_vol ? vol_period : decay;
   assign len_active = (len != '0);
   assign volume     = len_active ? env_out : '0;

endmodule

// File: tb/tb_apu_envelope_length.sv
// Directed bench for apu_envelope_length: expected {len_active, volume} pairs
// are queued as stimulus is driven and checked when the outputs are sampled.
module tb_apu_envelope_length;

   logic       clk;
   logic       rst_n;
   logic       fc_qfr_clk;
   logic       fc_hfr_clk;
   logic       enable;
   logic       wr_ctrl;
   logic [5:0] ctrl_data;
   logic       wr_len;
   logic [4:0] len_index;
   logic [3:0] volume;
   logic       len_active;

   logic [4:0] exp_q[$];
   int         total;
   int         bad;

   apu_envelope_length #(.LEN_W(8), .ENV_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fc_qfr_clk (fc_qfr_clk),
      .fc_hfr_clk (fc_hfr_clk),
      .enable     (enable),
      .wr_ctrl    (wr_ctrl),
      .ctrl_data  (ctrl_data),
      .wr_len     (wr_len),
      .len_index  (len_index),
      .volume     (volume),
      .len_active (len_active)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic qfr_edges(input int n);
      for (int i = 0; i < n; i++) begin
         fc_qfr_clk = 1'b1;
         step();
         fc_qfr_clk = 1'b0;
         step();
      end
   endtask

   task automatic hfr_edges(input int n);
      for (int i = 0; i < n; i++) begin
         fc_hfr_clk = 1'b1;
         step();
         fc_hfr_clk = 1'b0;
         step();
      end
   endtask

   task automatic write_ctrl(input logic [5:0] d);
      wr_ctrl   = 1'b1;
      ctrl_data = d;
      step();
      wr_ctrl   = 1'b0;
   endtask

   task automatic load_len(input logic [4:0] idx);
      wr_len    = 1'b1;
      len_index = idx;
      step();
      wr_len    = 1'b0;
   endtask

   task automatic expect_out(input logic act, input logic [3:0] vol);
      exp_q.push_back({act, vol});
   endtask

   task automatic check(input string tag);
      logic [4:0] exp_v;
      logic [4:0] obs;
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s scoreboard empty", tag);
         return;
      end
      exp_v = exp_q.pop_front();
      obs   = {len_active, volume};
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed act=%b vol=%0d expected act=%b vol=%0d",
                tag, obs[4], obs[3:0], exp_v[4], exp_v[3:0]);
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      rst_n      = 1'b0;
      fc_qfr_clk = 1'b1;
      fc_hfr_clk = 1'b1;
      enable     = 1'b0;
      wr_ctrl    = 1'b0;
      ctrl_data  = '0;
      wr_len     = 1'b0;
      len_index  = '0;

      // Reset with both toggle clocks held high
      repeat (3) step();
      expect_out(1'b0, 4'd0); check("reset");
      rst_n = 1'b1;
      step();
      expect_out(1'b0, 4'd0); check("release");

      // Load with the quarter-frame clock still high: no edge, envelope not started
      enable = 1'b1;
      write_ctrl(6'b000011);
      load_len(5'd1);
      step();
      step();
      expect_out(1'b1, 4'd0); check("no_evt_held_high");
      fc_qfr_clk = 1'b0;
      fc_hfr_clk = 1'b0;
      step();

      // Period 3 decay, no loop
      qfr_edges(1);  expect_out(1'b1, 4'd15); check("env_start");
      qfr_edges(3);  expect_out(1'b1, 4'd15); check("env_edge4");
      qfr_edges(1);  expect_out(1'b1, 4'd14); check("env_edge5");
      qfr_edges(56); expect_out(1'b1, 4'd0);  check("env_edge61");
      qfr_edges(8);  expect_out(1'b1, 4'd0);  check("env_hold0");

      // Looping envelope and halted length counter
      write_ctrl(6'b100011);
      load_len(5'd1);
      qfr_edges(61); expect_out(1'b1, 4'd0);  check("loop_edge61");
      qfr_edges(3);  expect_out(1'b1, 4'd0);  check("loop_edge64");
      qfr_edges(1);  expect_out(1'b1, 4'd15); check("loop_reload");
      hfr_edges(10); expect_out(1'b1, 4'd15); check("halt_len254");
      load_len(5'd3);
      hfr_edges(3);  expect_out(1'b1, 4'd15); check("halt_len2");
      write_ctrl(6'b000011);
      hfr_edges(1);  expect_out(1'b1, 4'd15); check("unhalt_dec1");
      hfr_edges(1);  expect_out(1'b0, 4'd0);  check("unhalt_zero");

      // Constant volume, length 2 runs out and stays at 0
      write_ctrl(6'b010111);
      load_len(5'd3); expect_out(1'b1, 4'd7); check("const_vol7");
      hfr_edges(1);   expect_out(1'b1, 4'd7); check("len2_dec1");
      hfr_edges(1);   expect_out(1'b0, 4'd0); check("len2_zero");
      hfr_edges(1);   expect_out(1'b0, 4'd0); check("len_no_wrap");

      // Load coinciding with a half-frame edge: load wins (len 5 -> 10)
      write_ctrl(6'b010101);
      load_len(5'd7);
      hfr_edges(1);   expect_out(1'b1, 4'd5); check("len6_dec");
      fc_hfr_clk = 1'b1;
      wr_len     = 1'b1;
      len_index  = 5'd0;
      step();
      wr_len     = 1'b0;
      fc_hfr_clk = 1'b0;
      step();
      expect_out(1'b1, 4'd5); check("load_vs_hfr");
      hfr_edges(9);   expect_out(1'b1, 4'd5); check("len10_after9");
      hfr_edges(1);   expect_out(1'b0, 4'd0); check("len10_after10");

      // Disable during a count of 40
      load_len(5'd4);
      hfr_edges(2);   expect_out(1'b1, 4'd5); check("len40_active");
      enable = 1'b0;
      step();
      expect_out(1'b0, 4'd0); check("disable_clears");

      // Bring decay to 0 with start clear, then load while disabled
      write_ctrl(6'b000000);
      qfr_edges(17);
      load_len(5'd1); expect_out(1'b0, 4'd0); check("load_blocked");

      // Start from the blocked load drives this quarter frame; the new load keeps start set
      enable     = 1'b1;
      fc_qfr_clk = 1'b1;
      wr_len     = 1'b1;
      len_index  = 5'd1;
      step();
      wr_len     = 1'b0;
      fc_qfr_clk = 1'b0;
      step();
      expect_out(1'b1, 4'd15); check("start_from_blocked");
      qfr_edges(1);  expect_out(1'b1, 4'd15); check("start_kept");
      qfr_edges(1);  expect_out(1'b1, 4'd14); check("decay_after_start");

      // Asynchronous reset mid-operation, half-frame clock held high across release
      rst_n      = 1'b0;
      fc_hfr_clk = 1'b1;
      #1;
      expect_out(1'b0, 4'd0); check("async_reset");
      step();
      rst_n = 1'b1;
      step();
      write_ctrl(6'b010111);
      load_len(5'd3);
      step();
      step();
      expect_out(1'b1, 4'd7); check("rearm_no_hfr");
      fc_hfr_clk = 1'b0;
      step();
      hfr_edges(1);  expect_out(1'b1, 4'd7); check("rearm_dec1");
      hfr_edges(1);  expect_out(1'b0, 4'd0); check("rearm_zero");

      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL leftover scoreboard entries=%0d", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
